// File: rtl/serial_work_dispatch.sv
// UART work dispatcher: streams a 64-byte work unit (midstate then data2) out on TxD
// and assembles 32-bit nonce words from RxD, with the two directions fully independent.
module serial_work_dispatch #(
  parameter int unsigned comm_clk_frequency = 130_000_000,
  parameter int unsigned baud_rate          = 115_200,
  parameter int unsigned gap_bits           = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] midstate,
  input  logic [255:0] data2,
  output logic         TxD,
  input  logic         RxD,
  output logic [31:0]  nonce,
  output logic         nonce_valid,
  output logic         exhausted,
  output logic         tx_done,
  output logic         frame_error
);

  localparam int unsigned Bit       = comm_clk_frequency / baud_rate;
  localparam int unsigned Half      = Bit / 2;
  localparam int unsigned GapCycles = gap_bits * Bit;
  localparam int unsigned CntW      = (Bit > 2) ? $clog2(Bit) : 1;
  localparam int unsigned GapW      = (GapCycles > 2) ? $clog2(GapCycles) : 1;

  localparam logic [CntW-1:0] BitLast  = CntW'(Bit - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
  localparam logic [GapW-1:0] GapLast  = GapW'(GapCycles - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // ---------------- transmitter ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [CntW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [5:0]       tx_byte_q, tx_byte_d;
  logic [511:0]     tx_data_q, tx_data_d;
  logic             txd_q, txd_d;
  logic             tx_done_q, tx_done_d;
  logic             armed_q;
  logic             tx_bit_end;

  // Holds work_ready low until the first clock edge after reset release.
  assign work_ready = armed_q && (tx_state_q == TxIdle);
  assign tx_bit_end = (tx_cnt_q == BitLast);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_data_d  = tx_data_q;
    txd_d      = txd_q;
    tx_done_d  = 1'b0;
    if (tx_state_q != TxIdle) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CntW'(1);
    end
    unique case (tx_state_q)
      TxIdle: begin
        if (work_valid && work_ready) begin
          tx_state_d = TxStart;
          tx_data_d  = {data2, midstate};
          tx_cnt_d   = '0;
          tx_byte_d  = '0;
          txd_d      = 1'b0;
        end
      end
      TxStart: begin
        if (tx_bit_end) begin
          tx_state_d = TxData;
          tx_bit_d   = '0;
          txd_d      = tx_data_q[0];
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          // The whole 512-bit unit is one LSB-first stream, so a single shift suffices.
          tx_data_d = tx_data_q >> 1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TxStop;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txd_d    = tx_data_q[1];
          end
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          if (tx_byte_q == 6'd63) begin
            tx_state_d = TxIdle;
            tx_done_d  = 1'b1;
          end else begin
            tx_state_d = TxStart;
            tx_byte_d  = tx_byte_q + 6'd1;
            txd_d      = 1'b0;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_data_q  <= '0;
      txd_q      <= 1'b1;
      tx_done_q  <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_data_q  <= tx_data_d;
      txd_q      <= txd_d;
      tx_done_q  <= tx_done_d;
      armed_q    <= 1'b1;
    end
  end

  assign TxD     = txd_q;
  assign tx_done = tx_done_q;

  // ---------------- receiver ----------------
  rx_state_e        rx_state_q, rx_state_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [1:0]       rx_nbytes_q, rx_nbytes_d;
  logic [31:0]      rx_word_q, rx_word_d;
  logic [GapW-1:0]  rx_gap_q, rx_gap_d;
  logic [31:0]      nonce_q, nonce_d;
  logic             nonce_valid_q, nonce_valid_d;
  logic             exhausted_q, exhausted_d;
  logic             frame_error_q, frame_error_d;
  logic             rx_start_edge;
  logic [31:0]      rx_word_new;

  assign rx_start_edge = rx_prev_q && !rx_sync_q;
  assign rx_word_new   = {rx_shift_q, rx_word_q[31:8]};

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_nbytes_d   = rx_nbytes_q;
    rx_word_d     = rx_word_q;
    rx_gap_d      = rx_gap_q;
    nonce_d       = nonce_q;
    nonce_valid_d = 1'b0;
    exhausted_d   = 1'b0;
    frame_error_d = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_start_edge) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
          rx_gap_d   = '0;
        end else if (rx_nbytes_q != 2'd0) begin
          // A stalled partial word is dropped without any pulse.
          if (rx_gap_q == GapLast) begin
            rx_nbytes_d = '0;
            rx_word_d   = '0;
            rx_gap_d    = '0;
          end else begin
            rx_gap_d = rx_gap_q + GapW'(1);
          end
        end
      end
      RxStart: begin
        rx_cnt_d = rx_cnt_q + CntW'(1);
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        rx_cnt_d = rx_cnt_q + CntW'(1);
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RxStop: begin
        rx_cnt_d = rx_cnt_q + CntW'(1);
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          if (!rx_sync_q) begin
            frame_error_d = 1'b1;
            rx_nbytes_d   = '0;
            rx_word_d     = '0;
          end else if (rx_nbytes_q == 2'd3) begin
            nonce_d       = rx_word_new;
            nonce_valid_d = (rx_word_new != 32'h0);
            exhausted_d   = (rx_word_new == 32'h0);
            rx_nbytes_d   = '0;
            rx_word_d     = '0;
          end else begin
            rx_word_d   = rx_word_new;
            rx_nbytes_d = rx_nbytes_q + 2'd1;
            rx_gap_d    = '0;
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RxIdle;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_nbytes_q   <= '0;
      rx_word_q     <= '0;
      rx_gap_q      <= '0;
      nonce_q       <= '0;
      nonce_valid_q <= 1'b0;
      exhausted_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_meta_q     <= RxD;
      rx_sync_q     <= rx_meta_q;
      rx_prev_q     <= rx_sync_q;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_nbytes_q   <= rx_nbytes_d;
      rx_word_q     <= rx_word_d;
      rx_gap_q      <= rx_gap_d;
      nonce_q       <= nonce_d;
      nonce_valid_q <= nonce_valid_d;
      exhausted_q   <= exhausted_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign nonce       = nonce_q;
  assign nonce_valid = nonce_valid_q;
  assign exhausted   = exhausted_q;
  assign frame_error = frame_error_q;

endmodule
